reorder_schedule_unit: RTL and testbench
========================================

// Module: reorder_schedule_unit
// PURPOSE
//  Parametrised in-order-commit scheduling buffer for the out-of-order core.
//  Allocates a tag per issued instruction and tracks register renaming for rs1/rs2 lookup.
//  Accepts results from N_CH completion channels (ALU, memory, ...) and commits in program order.
//  Checks branch prediction at commit and flushes the pipeline on mispredict.
// PARAMETERS
//  DEPTH  8   entries; power of two, >=2
//  ID_W   3   tag width = log2(DEPTH)
//  N_CH   2   completion channels; channel 0 has highest priority
// PORTS
//  clk_in                        in   1          system clock
//  rst_in                        in   1          synchronous, active-high reset
//  rdy_in                        in   1          low = freeze all state
//  issue_valid                   in   1          issue request
//  issue_ready                   out  1          count < DEPTH
//  issue_PC                      in   32         PC of issued instruction
//  issue_predicted_resulting_PC  in   32         predicted next PC
//  issue_rd/rs1/rs2              in   5 each     register ids; rd=0 means no write
//  issue_id                      out  ID_W       tag allocated (tail pointer)
//  rsN_busy (N=1,2)              out  1          rsN renamed to an uncommitted entry
//  rsN_tag                       out  ID_W       producer tag
//  rsN_fwd_valid                 out  1          producer already complete
//  rsN_fwd_val                   out  32         producer result
//  cpl_valid                     in   N_CH       per-channel completion strobe
//  cpl_id                        in   N_CH*ID_W  completing tag, packed; ch i at [i*ID_W+:ID_W]
//  cpl_val                       in   N_CH*32    results, packed
//  cpl_resulting_PC              in   N_CH*32    actual next PC, packed
//  is_writing_rd                 out  1          commit write strobe, registered
//  rd_reg_id                     out  5          commit destination
//  rd_val                        out  32         commit value
//  commit_id                     out  ID_W       tag of committed entry
//  flush_pipline                 out  1          one-cycle flush pulse, registered
//  reset_PC_to                   out  32         redirect PC, valid with flush_pipline
//  count                         out  ID_W+1     occupied entries
// BEHAVIOUR
//  Reset (rst_in=1 at posedge): head=tail=count=0; all entries invalid; rename table clear.
//   Registered outputs (is_writing_rd, flush_pipline, rd_*, reset_PC_to, commit_id) go to 0.
//   Reset mid-operation discards all in-flight entries.
//  rdy_in=0: no state change; is_writing_rd=0 and flush_pipline=0 on the next edge.
//  Issue: accepted when issue_valid & issue_ready. Entry[tail] is written and tail wraps mod DEPTH.
//   If rd!=0, rename[rd] <= tail. issue_ready uses registered count only, so a full buffer
//   rejects issue even if a commit occurs in the same cycle.
//  Completion: each valid channel whose tag addresses a valid, incomplete entry marks it
//   complete and stores val/resulting_PC. Tags for invalid entries are ignored.
//   If two channels carry the same tag, the lowest channel index wins.
//  Commit: at most one per cycle, when entry[head] is valid and complete. Commit latency >= 1
//   cycle after completion; outputs registered.
//   is_writing_rd=1 only if rd!=0. rename[rd] is cleared only if it still equals head.
//   A same-cycle issue to the same rd wins.
//  Mispredict: if the committed resulting_PC != predicted, then next cycle:
//   flush_pipline=1, reset_PC_to=resulting_PC; the committed rd write still occurs.
//   All entries, rename table and pointers are cleared; an issue in the same cycle is dropped.
//  count: +1 on issue, -1 on commit, unchanged on both; 0 after flush.
//  Lookup (combinational on registered state): rsN_busy = rename valid and rsN!=0;
//   fwd_valid/fwd_val come from entry[tag].
// CONFIGURATION
//  RSU_CPL_BYPASS_EN defined: rsN_fwd_valid/val also forward this cycle's matching completion
//   (channel priority applies).
//  RSU_CPL_BYPASS_EN undefined: lookup reflects registered entry state only
//   (one extra cycle to see a result).
// TESTING
//  Fill: DEPTH=8, issue 8 with no completions -> issue_ready=0, count=8;
//   the 9th request is not accepted; tail wraps to 0.
//  Out-of-order completion: issue tags 0,1,2; complete 2,1,0 on ch1,ch0,ch1 ->
//   commits in order 0,1,2 on consecutive cycles with matching rd_val.
//  Mispredict: tag0 predicted 0x104, resulting 0x200; tags 1-3 pending ->
//   flush_pipline=1 for 1 cycle, reset_PC_to=0x200, count=0, tag0 rd written.
//  Rename: issue rd=5 (tag0), then rd=5 (tag1); commit tag0 -> rs1=5 lookup gives busy=1, tag=1;
//   rd=0 never asserts is_writing_rd.
//  Collision: ch0 and ch1 both complete tag3, vals 0xA/0xB -> stored 0xA;
//   completion to an empty slot is ignored.
//  Stall/reset: rdy_in=0 for 3 cycles mid-stream -> count/pointers frozen;
//   rst_in pulse with 5 entries -> count=0, all outputs 0 next cycle.

Source files
------------

// File: rtl/reorder_schedule_unit.sv
// -----------------------------------------------------------------------------
// reorder_schedule_unit
//
// In-order-commit scheduling buffer for the out-of-order core. Each issued
// instruction gets a tag (the tail slot). The buffer records register renaming
// for rs1/rs2 lookup and takes results from N_CH completion channels, where
// channel 0 has the highest priority. Entries commit strictly in program order.
// At commit the predicted next PC is compared with the actual one. A mismatch
// causes a one-cycle flush that clears every in-flight entry.
//
// Configuration macro:
//   RSU_CPL_BYPASS_EN  When defined, rsN_fwd_valid/rsN_fwd_val also forward
//                      a completion arriving in the current cycle. When it is
//                      undefined, lookup shows registered entry state only.
//
// Ports:
//   clk_in, rst_in                 clock, synchronous active-high reset
//   rdy_in                         low = hold all state
//   issue_valid/issue_ready        issue handshake (ready = count < DEPTH)
//   issue_PC, issue_predicted_resulting_PC, issue_rd/rs1/rs2   issue payload
//   issue_id                       tag allocated to this issue
//   rsN_busy/tag/fwd_valid/fwd_val rename lookup for rs1 and rs2
//   cpl_valid/cpl_id/cpl_val/cpl_resulting_PC   packed completion channels
//   is_writing_rd, rd_reg_id, rd_val, commit_id  registered commit outputs
//   flush_pipline, reset_PC_to     registered mispredict redirect
//   count                          occupied entries
// -----------------------------------------------------------------------------
module reorder_schedule_unit #(
  parameter int DEPTH = 8,
  parameter int ID_W  = 3,
  parameter int N_CH  = 2
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 issue_valid,
  output logic                 issue_ready,
  input  logic [31:0]          issue_PC,
  input  logic [31:0]          issue_predicted_resulting_PC,
  input  logic [4:0]           issue_rd,
  input  logic [4:0]           issue_rs1,
  input  logic [4:0]           issue_rs2,
  output logic [ID_W-1:0]      issue_id,
  output logic                 rs1_busy,
  output logic [ID_W-1:0]      rs1_tag,
  output logic                 rs1_fwd_valid,
  output logic [31:0]          rs1_fwd_val,
  output logic                 rs2_busy,
  output logic [ID_W-1:0]      rs2_tag,
  output logic                 rs2_fwd_valid,
  output logic [31:0]          rs2_fwd_val,
  input  logic [N_CH-1:0]      cpl_valid,
  input  logic [N_CH*ID_W-1:0] cpl_id,
  input  logic [N_CH*32-1:0]   cpl_val,
  input  logic [N_CH*32-1:0]   cpl_resulting_PC,
  output logic                 is_writing_rd,
  output logic [4:0]           rd_reg_id,
  output logic [31:0]          rd_val,
  output logic [ID_W-1:0]      commit_id,
  output logic                 flush_pipline,
  output logic [31:0]          reset_PC_to,
  output logic [ID_W:0]        count
);

  localparam logic [ID_W:0] CNT_FULL = (ID_W+1)'(DEPTH);

  // Pointers and occupancy
  logic [ID_W-1:0]  head_q, head_d;
  logic [ID_W-1:0]  tail_q, tail_d;
  logic [ID_W:0]    count_q, count_d;

  // Entry control bits (these are reset)
  logic [DEPTH-1:0] ent_valid_q, ent_valid_d;
  logic [DEPTH-1:0] ent_done_q, ent_done_d;

  // Entry payload (not reset; qualified by the control bits)
  logic [4:0]       ent_rd_q   [DEPTH];
  logic [4:0]       ent_rd_d   [DEPTH];
  logic [31:0]      ent_pred_q [DEPTH];
  logic [31:0]      ent_pred_d [DEPTH];
  logic [31:0]      ent_val_q  [DEPTH];
  logic [31:0]      ent_val_d  [DEPTH];
  logic [31:0]      ent_res_q  [DEPTH];
  logic [31:0]      ent_res_d  [DEPTH];

  // Rename table: one entry per architectural register
  logic [31:0]      ren_valid_q, ren_valid_d;
  logic [ID_W-1:0]  ren_tag_q [32];
  logic [ID_W-1:0]  ren_tag_d [32];

  // Registered commit / flush outputs
  logic             is_writing_rd_q, is_writing_rd_d;
  logic [4:0]       rd_reg_id_q, rd_reg_id_d;
  logic [31:0]      rd_val_q, rd_val_d;
  logic [ID_W-1:0]  commit_id_q, commit_id_d;
  logic             flush_pipline_q, flush_pipline_d;
  logic [31:0]      reset_pc_to_q, reset_pc_to_d;

  // Unpacked completion channels
  logic [ID_W-1:0]  cpl_id_ch  [N_CH];
  logic [31:0]      cpl_val_ch [N_CH];
  logic [31:0]      cpl_res_ch [N_CH];
  logic [N_CH-1:0]  cpl_hit;

  logic             issue_fire;
  logic             commit_fire;
  logic             mispredict;
  logic [4:0]       head_rd;

  // The buffer never needs the issuing PC itself, only the predicted and
  // the resolved next PC.
  logic             unused_issue_pc;
  assign unused_issue_pc = ^issue_PC;

  assign issue_ready = (count_q < CNT_FULL);
  assign issue_fire  = rdy_in & issue_valid & issue_ready;
  assign head_rd     = ent_rd_q[head_q];
  // The head commits only once its done bit is registered, so commit comes
  // at least one cycle after completion.
  assign commit_fire = rdy_in & ent_valid_q[head_q] & ent_done_q[head_q];
  assign mispredict  = commit_fire & (ent_res_q[head_q] != ent_pred_q[head_q]);

  // A channel hits only when it addresses an occupied, not-yet-complete slot.
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      cpl_id_ch[i]  = cpl_id[i*ID_W +: ID_W];
      cpl_val_ch[i] = cpl_val[i*32 +: 32];
      cpl_res_ch[i] = cpl_resulting_PC[i*32 +: 32];
      cpl_hit[i]    = rdy_in & cpl_valid[i] & ent_valid_q[cpl_id_ch[i]]
                      & ~ent_done_q[cpl_id_ch[i]];
    end
  end

  // Next-state logic
  always_comb begin
    // NOTE: every _d starts as a copy of its _q, so a path that does not
    // assign a signal holds its state instead of inferring a latch.
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    ent_valid_d = ent_valid_q;
    ent_done_d  = ent_done_q;
    ent_rd_d    = ent_rd_q;
    ent_pred_d  = ent_pred_q;
    ent_val_d   = ent_val_q;
    ent_res_d   = ent_res_q;
    ren_valid_d = ren_valid_q;
    ren_tag_d   = ren_tag_q;

    // Completion. Channels are walked from high to low index, so channel 0
    // writes last and wins a tag collision.
    for (int i = N_CH-1; i >= 0; i--) begin
      if (cpl_hit[i]) begin
        ent_done_d[cpl_id_ch[i]] = 1'b1;
        ent_val_d[cpl_id_ch[i]]  = cpl_val_ch[i];
        ent_res_d[cpl_id_ch[i]]  = cpl_res_ch[i];
      end
    end

    // Commit. The rename entry is released only if it still points at the
    // committing tag; a younger writer of the same rd keeps ownership.
    if (commit_fire) begin
      ent_valid_d[head_q] = 1'b0;
      ent_done_d[head_q]  = 1'b0;
      head_d              = head_q + ID_W'(1);
      if (ren_valid_q[head_rd] && (ren_tag_q[head_rd] == head_q)) begin
        ren_valid_d[head_rd] = 1'b0;
      end
    end

    // Issue. This comes after the commit release so that a same-cycle
    // issue to the same rd claims the rename entry.
    if (issue_fire) begin
      ent_valid_d[tail_q] = 1'b1;
      ent_done_d[tail_q]  = 1'b0;
      ent_rd_d[tail_q]    = issue_rd;
      ent_pred_d[tail_q]  = issue_predicted_resulting_PC;
      tail_d              = tail_q + ID_W'(1);
      if (issue_rd != 5'd0) begin
        ren_valid_d[issue_rd] = 1'b1;
        ren_tag_d[issue_rd]   = tail_q;
      end
    end

    case ({issue_fire, commit_fire})
      2'b10:   count_d = count_q + (ID_W+1)'(1);
      2'b01:   count_d = count_q - (ID_W+1)'(1);
      default: count_d = count_q;
    endcase

    // A mispredict discards everything younger than the committing entry,
    // including any issue or completion in this same cycle.
    if (mispredict) begin
      head_d      = '0;
      tail_d      = '0;
      count_d     = '0;
      ent_valid_d = '0;
      ent_done_d  = '0;
      ren_valid_d = '0;
    end
  end

  // Commit and flush output registers. The payload holds between commits.
  always_comb begin
    is_writing_rd_d = commit_fire && (head_rd != 5'd0);
    flush_pipline_d = mispredict;
    rd_reg_id_d     = commit_fire ? head_rd          : rd_reg_id_q;
    rd_val_d        = commit_fire ? ent_val_q[head_q] : rd_val_q;
    commit_id_d     = commit_fire ? head_q           : commit_id_q;
    reset_pc_to_d   = mispredict  ? ent_res_q[head_q] : reset_pc_to_q;
  end

  // Control state and registered outputs
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      head_q          <= '0;
      tail_q          <= '0;
      count_q         <= '0;
      ent_valid_q     <= '0;
      ent_done_q      <= '0;
      ren_valid_q     <= '0;
      is_writing_rd_q <= 1'b0;
      rd_reg_id_q     <= '0;
      rd_val_q        <= '0;
      commit_id_q     <= '0;
      flush_pipline_q <= 1'b0;
      reset_pc_to_q   <= '0;
    end else begin
      head_q          <= head_d;
      tail_q          <= tail_d;
      count_q         <= count_d;
      ent_valid_q     <= ent_valid_d;
      ent_done_q      <= ent_done_d;
      ren_valid_q     <= ren_valid_d;
      is_writing_rd_q <= is_writing_rd_d;
      rd_reg_id_q     <= rd_reg_id_d;
      rd_val_q        <= rd_val_d;
      commit_id_q     <= commit_id_d;
      flush_pipline_q <= flush_pipline_d;
      reset_pc_to_q   <= reset_pc_to_d;
    end
  end

  // NOTE: the payload arrays are left out of reset on purpose. The valid and
  // done bits qualify every read, so clearing the data would only add reset
  // fan-out. It would also keep these arrays from mapping to plain storage.
  always_ff @(posedge clk_in) begin
    ent_rd_q   <= ent_rd_d;
    ent_pred_q <= ent_pred_d;
    ent_val_q  <= ent_val_d;
    ent_res_q  <= ent_res_d;
    ren_tag_q  <= ren_tag_d;
  end

  // Operand lookup: combinational, on registered state
  logic [4:0]      rs_id        [2];
  logic            rs_busy      [2];
  logic [ID_W-1:0] rs_tag       [2];
  logic            rs_fwd_valid [2];
  logic [31:0]     rs_fwd_val   [2];

  always_comb begin
    rs_id[0] = issue_rs1;
    rs_id[1] = issue_rs2;
    for (int r = 0; r < 2; r++) begin
      rs_busy[r]      = ren_valid_q[rs_id[r]] && (rs_id[r] != 5'd0);
      rs_tag[r]       = ren_tag_q[rs_id[r]];
      rs_fwd_valid[r] = rs_busy[r] && ent_done_q[rs_tag[r]];
      rs_fwd_val[r]   = ent_val_q[rs_tag[r]];
`ifdef RSU_CPL_BYPASS_EN
      // Forward a completion landing this cycle. A hit implies the slot is
      // not yet done, and channel 0 is applied last so it wins.
      for (int i = N_CH-1; i >= 0; i--) begin
        if (rs_busy[r] && cpl_hit[i] && (cpl_id_ch[i] == rs_tag[r])) begin
          rs_fwd_valid[r] = 1'b1;
          rs_fwd_val[r]   = cpl_val_ch[i];
        end
      end
`endif
    end
  end

  assign rs1_busy      = rs_busy[0];
  assign rs1_tag       = rs_tag[0];
  assign rs1_fwd_valid = rs_fwd_valid[0];
  assign rs1_fwd_val   = rs_fwd_val[0];
  assign rs2_busy      = rs_busy[1];
  assign rs2_tag       = rs_tag[1];
  assign rs2_fwd_valid = rs_fwd_valid[1];
  assign rs2_fwd_val   = rs_fwd_val[1];

  assign issue_id      = tail_q;
  assign count         = count_q;
  assign is_writing_rd = is_writing_rd_q;
  assign rd_reg_id     = rd_reg_id_q;
  assign rd_val        = rd_val_q;
  assign commit_id     = commit_id_q;
  assign flush_pipline = flush_pipline_q;
  assign reset_PC_to   = reset_pc_to_q;

endmodule

// File: tb/tb_reorder_schedule_unit.sv
`timescale 1ns/1ps
module tb_reorder_schedule_unit;
  localparam int DEPTH = 8;
  localparam int ID_W  = 3;
  localparam int N_CH  = 2;

  logic                 clk_in = 1'b0;
  logic                 rst_in, rdy_in, issue_valid, issue_ready;
  logic [31:0]          issue_PC, issue_predicted_resulting_PC;
  logic [4:0]           issue_rd, issue_rs1, issue_rs2;
  logic [ID_W-1:0]      issue_id;
  logic                 rs1_busy, rs1_fwd_valid, rs2_busy, rs2_fwd_valid;
  logic [ID_W-1:0]      rs1_tag, rs2_tag;
  logic [31:0]          rs1_fwd_val, rs2_fwd_val;
  logic [N_CH-1:0]      cpl_valid;
  logic [N_CH*ID_W-1:0] cpl_id;
  logic [N_CH*32-1:0]   cpl_val, cpl_resulting_PC;
  logic                 is_writing_rd, flush_pipline;
  logic [4:0]           rd_reg_id;
  logic [31:0]          rd_val, reset_PC_to;
  logic [ID_W-1:0]      commit_id;
  logic [ID_W:0]        count;

  reorder_schedule_unit #(.DEPTH(DEPTH), .ID_W(ID_W), .N_CH(N_CH)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_PC(issue_PC),
    .issue_predicted_resulting_PC(issue_predicted_resulting_PC),
    .issue_rd(issue_rd), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
    .issue_id(issue_id),
    .rs1_busy(rs1_busy), .rs1_tag(rs1_tag), .rs1_fwd_valid(rs1_fwd_valid), .rs1_fwd_val(rs1_fwd_val),
    .rs2_busy(rs2_busy), .rs2_tag(rs2_tag), .rs2_fwd_valid(rs2_fwd_valid), .rs2_fwd_val(rs2_fwd_val),
    .cpl_valid(cpl_valid), .cpl_id(cpl_id), .cpl_val(cpl_val), .cpl_resulting_PC(cpl_resulting_PC),
    .is_writing_rd(is_writing_rd), .rd_reg_id(rd_reg_id), .rd_val(rd_val), .commit_id(commit_id),
    .flush_pipline(flush_pipline), .reset_PC_to(reset_PC_to), .count(count)
  );

  always #5 clk_in = ~clk_in;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [ID_W-1:0] id;
    logic [4:0]      rd;
    logic [31:0]     val;
  } sb_t;
  sb_t sb[$];

  // Per-tag values the bench will complete with
  logic [31:0]     exp_val [DEPTH];
  logic [31:0]     exp_res [DEPTH];
  logic [ID_W-1:0] m_tail;

  typedef struct {
    logic            iv;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic            e_ready;
    logic [ID_W-1:0] e_id;
    logic [ID_W:0]   e_count;
    logic            e_busy;
    logic [ID_W-1:0] e_tag;
  } vec_t;
  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle_inputs();
    issue_valid = 1'b0; issue_PC = '0; issue_predicted_resulting_PC = '0;
    issue_rd = '0; issue_rs1 = '0; issue_rs2 = '0;
    cpl_valid = '0; cpl_id = '0; cpl_val = '0; cpl_resulting_PC = '0;
  endtask

  task automatic do_issue(input logic [4:0] rd, input logic [31:0] val,
                          input logic [31:0] pred, input logic [31:0] res);
    sb_t e;
    check("issue_ready", {31'd0, issue_ready}, 32'd1);
    check("issue_id", {29'd0, issue_id}, {29'd0, m_tail});
    issue_valid = 1'b1; issue_rd = rd; issue_PC = 32'h1000 + 32'(m_tail) * 4;
    issue_predicted_resulting_PC = pred;
    exp_val[m_tail] = val; exp_res[m_tail] = res;
    if (rd != 5'd0) begin
      e.id = m_tail; e.rd = rd; e.val = val;
      sb.push_back(e);
    end
    step();
    issue_valid = 1'b0;
    m_tail = m_tail + 1'b1;
  endtask

  task automatic complete(input logic v0, input int t0, input logic [31:0] val0,
                          input logic v1, input int t1, input logic [31:0] val1);
    cpl_valid = {v1, v0};
    cpl_id = {ID_W'(t1), ID_W'(t0)};
    cpl_val = {val1, val0};
    cpl_resulting_PC = {exp_res[t1], exp_res[t0]};
    step();
    cpl_valid = '0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 40 && count != 0; i++) step();
    check(name, 32'(count), 32'd0);
  endtask

  // Commit scoreboard: every rd write must match the oldest expected entry
  always @(negedge clk_in) begin
    sb_t e;
    if (!rst_in && is_writing_rd) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL commit_unexpected: rd=%0d val=%h, scoreboard empty", rd_reg_id, rd_val);
      end else begin
        e = sb.pop_front();
        check("commit_id", 32'(commit_id), 32'(e.id));
        check("commit_rd", 32'(rd_reg_id), 32'(e.rd));
        check("commit_val", rd_val, e.val);
      end
    end
  end

  initial begin
    int t0;
    for (int i = 0; i < 8; i++) begin
      vecs[i] = '{iv: 1'b1, rd: 5'(i+1), rs1: 5'(i), e_ready: 1'b1, e_id: ID_W'(i),
                  e_count: (ID_W+1)'(i), e_busy: (i > 0), e_tag: ID_W'(i-1)};
    end
    vecs[8] = '{iv: 1'b1, rd: 5'd9, rs1: 5'd8, e_ready: 1'b0, e_id: '0,
                e_count: (ID_W+1)'(8), e_busy: 1'b1, e_tag: ID_W'(7)};
    vecs[9] = '{iv: 1'b0, rd: 5'd0, rs1: 5'd9, e_ready: 1'b0, e_id: '0,
                e_count: (ID_W+1)'(8), e_busy: 1'b0, e_tag: '0};

    // Reset state
    idle_inputs(); rdy_in = 1'b1; rst_in = 1'b1; m_tail = '0;
    step(); step();
    rst_in = 1'b0;
    check("rst_count", 32'(count), 32'd0);
    check("rst_ready", 32'(issue_ready), 32'd1);
    check("rst_wr", 32'(is_writing_rd), 32'd0);
    check("rst_flush", 32'(flush_pipline), 32'd0);
    check("rst_pc", reset_PC_to, 32'd0);

    // Fill to DEPTH, with rename lookup of the previous rd on each row
    for (int i = 0; i < 10; i++) begin
      issue_valid = vecs[i].iv; issue_rd = vecs[i].rd; issue_rs1 = vecs[i].rs1;
      issue_predicted_resulting_PC = 32'h2000 + 32'(i) * 4;
      #1;
      check($sformatf("fill%0d_ready", i), 32'(issue_ready), 32'(vecs[i].e_ready));
      check($sformatf("fill%0d_id", i), 32'(issue_id), 32'(vecs[i].e_id));
      check($sformatf("fill%0d_count", i), 32'(count), 32'(vecs[i].e_count));
      check($sformatf("fill%0d_busy", i), 32'(rs1_busy), 32'(vecs[i].e_busy));
      if (vecs[i].e_busy) check($sformatf("fill%0d_tag", i), 32'(rs1_tag), 32'(vecs[i].e_tag));
      if (vecs[i].iv && vecs[i].e_ready) begin
        exp_val[i] = 32'h100 + 32'(i);
        exp_res[i] = issue_predicted_resulting_PC;
        sb.push_back('{id: ID_W'(i), rd: vecs[i].rd, val: exp_val[i]});
        m_tail = m_tail + 1'b1;
      end
      step();
    end
    idle_inputs();
    for (int j = 0; j < 4; j++) complete(1'b1, 7-2*j, exp_val[7-2*j], 1'b1, 6-2*j, exp_val[6-2*j]);
    drain("fill_drain");

    // Out-of-order completion, in-order commit
    do_issue(5'd10, 32'hA0A0_0010, 32'h3004, 32'h3004);
    do_issue(5'd11, 32'hA0A0_0011, 32'h3008, 32'h3008);
    do_issue(5'd12, 32'hA0A0_0012, 32'h300C, 32'h300C);
    complete(1'b0, 0, 32'd0, 1'b1, 2, exp_val[2]);
    complete(1'b1, 1, exp_val[1], 1'b0, 0, 32'd0);
    complete(1'b0, 0, 32'd0, 1'b1, 0, exp_val[0]);
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("ooo_wr%0d", k), 32'(is_writing_rd), 32'd1);
      check($sformatf("ooo_id%0d", k), 32'(commit_id), 32'(k));
    end
    step();
    check("ooo_idle", 32'(is_writing_rd), 32'd0);
    check("ooo_count", 32'(count), 32'd0);

    // Mispredict with younger entries pending and a same-cycle issue
    t0 = int'(m_tail);
    do_issue(5'd7, 32'h77, 32'h104, 32'h200);
    do_issue(5'd8, 32'h88, 32'h4000, 32'h4000);
    do_issue(5'd9, 32'h99, 32'h4004, 32'h4004);
    do_issue(5'd10, 32'hAA, 32'h4008, 32'h4008);
    complete(1'b1, t0+1, exp_val[(t0+1)%DEPTH], 1'b1, t0+2, exp_val[(t0+2)%DEPTH]);
    complete(1'b1, t0, 32'h77, 1'b0, 0, 32'd0);
    issue_valid = 1'b1; issue_rd = 5'd20;
    step();
    idle_inputs(); issue_rs1 = 5'd8;
    #1;
    check("mp_flush", 32'(flush_pipline), 32'd1);
    check("mp_pc", reset_PC_to, 32'h200);
    check("mp_wr", 32'(is_writing_rd), 32'd1);
    check("mp_rd", 32'(rd_reg_id), 32'd7);
    check("mp_count", 32'(count), 32'd0);
    check("mp_tail", 32'(issue_id), 32'd0);
    check("mp_rename", 32'(rs1_busy), 32'd0);
    step();
    check("mp_flush_off", 32'(flush_pipline), 32'd0);
    check("mp_sb_left", 32'(sb.size()), 32'd3);
    sb.delete(); m_tail = '0;

    // Rename: two writers of rd=5, then an rd=0 entry
    do_issue(5'd5, 32'h55, 32'h5000, 32'h5000);
    do_issue(5'd5, 32'h56, 32'h5004, 32'h5004);
    do_issue(5'd0, 32'h99, 32'h5008, 32'h5008);
    issue_rs1 = 5'd5; issue_rs2 = 5'd5;
    #1;
    check("ren_busy", 32'(rs1_busy), 32'd1);
    check("ren_tag", 32'(rs1_tag), 32'd1);
    check("ren_tag2", 32'(rs2_tag), 32'd1);
    check("ren_fwd0", 32'(rs1_fwd_valid), 32'd0);
    cpl_valid = 2'b01; cpl_id = {ID_W'(0), ID_W'(1)};
    cpl_val = {32'd0, exp_val[1]}; cpl_resulting_PC = {32'd0, exp_res[1]};
    #1;
`ifdef RSU_CPL_BYPASS_EN
    check("ren_bypass", 32'(rs1_fwd_valid), 32'd1);
`else
    check("ren_bypass", 32'(rs1_fwd_valid), 32'd0);
`endif
    step();
    cpl_valid = '0;
    check("ren_fwd1", 32'(rs1_fwd_valid), 32'd1);
    check("ren_fwdval", rs1_fwd_val, 32'h56);
    complete(1'b1, 0, exp_val[0], 1'b0, 0, 32'd0);
    step();
    check("ren_keep_busy", 32'(rs1_busy), 32'd1);
    check("ren_keep_tag", 32'(rs1_tag), 32'd1);
    complete(1'b1, 2, exp_val[2], 1'b0, 0, 32'd0);
    drain("ren_drain");
    check("ren_released", 32'(rs1_busy), 32'd0);
    idle_inputs();

    // Collision on one tag, and a completion to an empty slot
    complete(1'b0, 0, 32'd0, 1'b1, 4, 32'hDEAD);
    do_issue(5'd12, 32'hA, 32'h6000, 32'h6000);
    do_issue(5'd13, 32'h44, 32'h6004, 32'h6004);
    issue_rs1 = 5'd13;
    #1;
    check("col_empty_busy", 32'(rs1_busy), 32'd1);
    check("col_empty_ign", 32'(rs1_fwd_valid), 32'd0);
    complete(1'b1, 3, 32'hA, 1'b1, 3, 32'hB);
    step(); step(); step();
    check("col_count", 32'(count), 32'd1);
    complete(1'b1, 4, 32'h44, 1'b0, 0, 32'd0);
    drain("col_drain");
    idle_inputs();

    // Stall: rdy_in low for 3 cycles with issue and completion pending
    do_issue(5'd14, 32'h1414, 32'h7000, 32'h7000);
    do_issue(5'd15, 32'h1515, 32'h7004, 32'h7004);
    check("stall_pre_count", 32'(count), 32'd2);
    rdy_in = 1'b0; issue_valid = 1'b1; issue_rd = 5'd16;
    cpl_valid = 2'b01; cpl_id = {ID_W'(0), ID_W'(5)};
    cpl_val = {32'd0, exp_val[5]}; cpl_resulting_PC = {32'd0, exp_res[5]};
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("stall%0d_count", k), 32'(count), 32'd2);
      check($sformatf("stall%0d_tail", k), 32'(issue_id), 32'd7);
      check($sformatf("stall%0d_wr", k), 32'(is_writing_rd), 32'd0);
    end
    rdy_in = 1'b1; idle_inputs(); issue_rs1 = 5'd14;
    #1;
    check("stall_cpl_ignored", 32'(rs1_fwd_valid), 32'd0);
    complete(1'b1, 5, exp_val[5], 1'b1, 6, exp_val[6]);
    drain("stall_drain");
    idle_inputs();

    // Reset pulse with 5 entries in flight
    for (int k = 0; k < 5; k++) do_issue(5'(17 + k), 32'hC000 + 32'(k), 32'h8000, 32'h8000);
    check("rst5_count", 32'(count), 32'd5);
    rst_in = 1'b1;
    step();
    rst_in = 1'b0;
    check("rst5_count0", 32'(count), 32'd0);
    check("rst5_wr", 32'(is_writing_rd), 32'd0);
    check("rst5_flush", 32'(flush_pipline), 32'd0);
    check("rst5_rd", 32'(rd_reg_id), 32'd0);
    check("rst5_val", rd_val, 32'd0);
    check("rst5_cid", 32'(commit_id), 32'd0);
    check("rst5_pc", reset_PC_to, 32'd0);
    check("rst5_tail", 32'(issue_id), 32'd0);
    sb.delete(); m_tail = '0;

    // Operation resumes after reset
    do_issue(5'd22, 32'h2222, 32'h9000, 32'h9000);
    complete(1'b1, 0, exp_val[0], 1'b0, 0, 32'd0);
    drain("post_rst_drain");
    step();
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
